// File: rtl/alu_pkg.sv
// Shared ALU control codes and the sequential multiplier state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_seq_mul_dp.sv
// Shift-add datapath: accumulator, shifting multiplicand/multiplier, step counter.
// ALU_SEQ_MUL_EARLY_EXIT_EN: finish as soon as no multiplier bits remain.
module alu_seq_mul_dp
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         calc_i,
    input  logic [N-1:0] op_a_i,
    input  logic [N-1:0] op_b_i,
    input  logic [N-1:0] alu_result_i,
    output logic [N-1:0] acc_o,
    output logic [N-1:0] mcand_o,
    output logic [N-1:0] acc_nxt_o,
    output logic         last_o
);

    localparam int CW = $clog2(N);

    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  mcand_q, mcand_d;
    logic [N-1:0]  mplier_q, mplier_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = op_a_i;
            mplier_d = op_b_i;
            cnt_d    = '0;
        end else if (calc_i) begin
            if (mplier_q[0])
                acc_d = alu_result_i;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
    assign last_o = (cnt_q == CW'(N - 1)) || (mplier_q[N-1:1] == '0);
`else
    assign last_o = (cnt_q == CW'(N - 1));
`endif

    assign acc_o     = acc_q;
    assign mcand_o   = mcand_q;
    assign acc_nxt_o = acc_d;

endmodule

// File: rtl/alu_seq_mul.sv
// Iterative LEGv8 MUL that borrows the execute-stage ALU adder.
// ALU_SEQ_MUL_EARLY_EXIT_EN: latency tracks the highest set multiplier bit.
module alu_seq_mul
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_ctl,
    input  logic [N-1:0] alu_result
);

    mul_state_t   state_q;
    logic         busy_q;
    logic         done_q;
    logic [N-1:0] product_q;
    logic         load;
    logic         calc;
    logic         last;
    logic [N-1:0] acc_nxt;

    assign load = (state_q == IDLE) && start;
    assign calc = (state_q == CALC);

    alu_seq_mul_dp #(.N(N)) u_dp (
        .clk          (clk),
        .reset        (reset),
        .load_i       (load),
        .calc_i       (calc),
        .op_a_i       (op_a),
        .op_b_i       (op_b),
        .alu_result_i (alu_result),
        .acc_o        (alu_a),
        .mcand_o      (alu_b),
        .acc_nxt_o    (acc_nxt),
        .last_o       (last)
    );

    // product is captured on entry to DONE so it is valid with done
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
                        if (op_b == '0) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            product_q <= '0;
                        end else begin
                            state_q <= CALC;
                        end
`else
                        state_q <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (last) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        product_q <= acc_nxt;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign alu_ctl = ALU_ADD;

endmodule

// File: tb/tb_alu_seq_mul.sv
// Bench for alu_seq_mul closed through a behavioural ALU; honours ALU_SEQ_MUL_EARLY_EXIT_EN.
module tb_alu_seq_mul;
    import alu_pkg::*;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         busy;
    logic         done;
    logic [N-1:0] product;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_ctl;
    logic [N-1:0] alu_result;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_seq_mul #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctl    (alu_ctl),
        .alu_result (alu_result)
    );

    // the execute-stage ALU the multiplier borrows
    always_comb begin
        alu_result = '0;
        case (alu_ctl)
            ALU_AND:   alu_result = alu_a & alu_b;
            ALU_OR:    alu_result = alu_a | alu_b;
            ALU_ADD:   alu_result = alu_a + alu_b;
            ALU_SUB:   alu_result = alu_a - alu_b;
            ALU_PASSB: alu_result = alu_b;
            default:   alu_result = '0;
        endcase
    end

    task automatic chk(input string nm, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // edges after the accepting edge until done is visible
    function automatic int lat_of(input logic [N-1:0] b);
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
        int h = 0;
        for (int i = 0; i < N; i++)
            if (b[i]) h = i + 1;
        return h;
`else
        return N;
`endif
    endfunction

    // model: idle / counting down to done, product from plain multiplication
    int           m_rem = -1;
    bit           m_done = 1'b0;
    logic [N-1:0] m_prod = '0;
    logic [N-1:0] m_pend = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_rem  <= -1;
            m_done <= 1'b0;
            m_prod <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_rem < 0) begin
            if (start) begin
                if (lat_of(op_b) == 0) begin
                    m_done <= 1'b1;
                    m_prod <= op_a * op_b;
                end else begin
                    m_rem  <= lat_of(op_b);
                    m_pend <= op_a * op_b;
                end
            end
        end else if (m_rem == 1) begin
            m_rem  <= -1;
            m_done <= 1'b1;
            m_prod <= m_pend;
        end else begin
            m_rem <= m_rem - 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {63'd0, busy}, {63'd0, (m_rem > 0) || m_done});
            chk("done", {63'd0, done}, {63'd0, m_done});
            chk("product", product, m_prod);
            chk("alu_ctl", {60'd0, alu_ctl}, {60'd0, ALU_ADD});
        end
    end

    task automatic run_mul(input string nm, input logic [N-1:0] a,
                           input logic [N-1:0] b, input logic [N-1:0] exp_p,
                           input int exp_lat, input bit inject);
        int k;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        start = 1'b0;
        op_a  = 64'h0123_4567_89AB_CDEF;
        op_b  = 64'hFEDC_BA98_7654_3210;
        k = 0;
        while (!done && k < 300) begin
            k++;
            start = inject && (k == 5);
            @(negedge clk);
        end
        start = 1'b0;
        if (k >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done after %0d cycles", nm, k);
        end
        chk({nm, " latency"}, 64'(k), 64'(exp_lat));
        chk({nm, " product"}, product, exp_p);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle busy", {63'd0, busy}, 64'd0);
        chk("idle done", {63'd0, done}, 64'd0);
        chk("idle product", product, 64'd0);
        chk("idle alu_ctl", {60'd0, alu_ctl}, 64'd2);

`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
        run_mul("3x5", 64'd3, 64'd5, 64'd15, 3, 1'b0);
        run_mul("7x0", 64'd7, 64'd0, 64'd0, 0, 1'b0);
        run_mul("msb x2", 64'h8000_0000_0000_0000, 64'd2, 64'd0, 2, 1'b0);
`else
        run_mul("3x5", 64'd3, 64'd5, 64'd15, 64, 1'b0);
        run_mul("7x0", 64'd7, 64'd0, 64'd0, 64, 1'b0);
        run_mul("msb x2", 64'h8000_0000_0000_0000, 64'd2, 64'd0, 64, 1'b0);
`endif
        run_mul("ones x ones", '1, '1, 64'd1, 64, 1'b0);
        run_mul("3x5 again", 64'd3, 64'd5, 64'd15, lat_of(64'd5), 1'b0);
        run_mul("mid start", 64'd11, 64'h8000_0000_0000_0001,
                64'h8000_0000_0000_000B, 64, 1'b1);

        start = 1'b1;
        op_a  = 64'd9;
        op_b  = '1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy before abort", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", {63'd0, busy}, 64'd0);
        chk("abort product", product, 64'd0);
        repeat (70) begin
            @(negedge clk);
            chk("abort no done", {63'd0, done}, 64'd0);
        end
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
        run_mul("6x7", 64'd6, 64'd7, 64'd42, 3, 1'b0);
`else
        run_mul("6x7", 64'd6, 64'd7, 64'd42, 64, 1'b0);
`endif
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
